// File: rtl/shared_reg_arbiter.sv
// Purpose: round-robin owner arbitration for one shared WIDTH-bit control register.
// Latency: req -> gnt one cycle; the owner's op -> q one cycle after gnt is visible.
// Backpressure: none; ops from non-owners are dropped, and the owner yields after MAX_HOLD cycles under contention.
module shared_reg_arbiter #(
   parameter int N_REQ    = 4,
   parameter int WIDTH    = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic                       clk,
   input  logic                       rst_b,
   input  logic [N_REQ-1:0]           req,
   input  logic [2*N_REQ-1:0]         op,
   input  logic [WIDTH*N_REQ-1:0]     wdata,
   output logic [N_REQ-1:0]           gnt,
   output logic                       gnt_vld,
   output logic [$clog2(N_REQ)-1:0]   gnt_id,
   output logic [WIDTH-1:0]           q
);

   localparam int IW = $clog2(N_REQ);
   localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
   localparam logic [IW-1:0] LAST_ID   = IW'(N_REQ - 1);

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   state_t           state_q;
   logic [IW-1:0]    ptr_q;
   logic [IW-1:0]    gnt_id_q;
   logic [HW-1:0]    hold_cnt_q;
   logic [N_REQ-1:0] gnt_q;
   logic             gnt_vld_q;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;

   logic             owner_req;
   logic             others_req;
   logic             rearb;
   logic             found;
   logic [IW-1:0]    win_id;
   logic [IW-1:0]    win_nxt;
   logic [IW-1:0]    idx;
   logic [1:0]       cur_op;
   logic [WIDTH-1:0] cur_wd;

   assign owner_req  = req[gnt_id_q];
   assign others_req = |(req & ~gnt_q);
   assign cur_op     = op[2*gnt_id_q +: 2];
   assign cur_wd     = wdata[WIDTH*gnt_id_q +: WIDTH];

   // Re-arbitrate when idle, or when the owner drops req or has used its hold budget while others wait.
   always_comb begin
      rearb = 1'b1;
      if (state_q == S_GRANT) begin
         rearb = !owner_req || ((hold_cnt_q == HOLD_LAST) && others_req);
      end
   end

   // Circular scan of req starting at the round-robin pointer.
   always_comb begin
      found  = 1'b0;
      win_id = '0;
      idx    = '0;
      for (int off = 0; off < N_REQ; off++) begin
         idx = IW'((int'(ptr_q) + off) % N_REQ);
         if (!found && req[idx]) begin
            found  = 1'b1;
            win_id = idx;
         end
      end
      win_nxt = (win_id == LAST_ID) ? '0 : win_id + 1'b1;
   end

   // Owner FSM: grant, pointer and hold counter, all registered.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state_q    <= S_IDLE;
         gnt_q      <= '0;
         gnt_vld_q  <= 1'b0;
         gnt_id_q   <= '0;
         ptr_q      <= '0;
         hold_cnt_q <= '0;
      end else if (rearb) begin
         hold_cnt_q <= '0;
         if (found) begin
            state_q   <= S_GRANT;
            gnt_q     <= {{(N_REQ-1){1'b0}}, 1'b1} << win_id;
            gnt_vld_q <= 1'b1;
            gnt_id_q  <= win_id;
            ptr_q     <= win_nxt;
         end else begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            gnt_vld_q <= 1'b0;
            gnt_id_q  <= '0;
         end
      end else if (hold_cnt_q != HOLD_LAST) begin
         hold_cnt_q <= hold_cnt_q + 1'b1;
      end
   end

   // Next register value: only the current owner, while still requesting, can change it.
   always_comb begin
      data_d = data_q;
      if ((state_q == S_GRANT) && owner_req) begin
         case (cur_op)
            2'b01:   data_d = cur_wd;
            2'b10:   data_d = '0;
            2'b11:   data_d = '1;
            default: data_d = data_q;
         endcase
      end
   end

   // Shared register flop; reset discards any op pending in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign gnt     = gnt_q;
   assign gnt_vld = gnt_vld_q;
   assign gnt_id  = gnt_id_q;
   assign q       = data_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed and randomized checks of shared_reg_arbiter against an ownership-tenure reference model.
module tb_shared_reg_arbiter;
   localparam int N  = 4;
   localparam int W  = 8;
   localparam int MH = 4;

   logic          clk;
   logic          rst_b;
   logic [N-1:0]  req;
   logic [2*N-1:0] op;
   logic [W*N-1:0] wdata;
   logic [N-1:0]  gnt;
   logic          gnt_vld;
   logic [1:0]    gnt_id;
   logic [W-1:0]  q;

   int total = 0;
   int bad   = 0;

   // reference model: who owns, how many consecutive cycles it has owned, scan start, register value
   int         m_owner = -1;
   int         m_ten   = 0;
   int         m_ptr   = 0;
   logic [7:0] m_q     = 8'h00;

   shared_reg_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_HOLD(MH)) dut (
      .clk(clk), .rst_b(rst_b), .req(req), .op(op), .wdata(wdata),
      .gnt(gnt), .gnt_vld(gnt_vld), .gnt_id(gnt_id), .q(q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model(input logic r_b, input logic [3:0] r, input logic [7:0] o, input logic [31:0] w);
      logic [7:0] nq;
      logic [1:0] oo;
      bit         others;
      bit         yield;
      int         k;
      if (!r_b) begin
         m_owner = -1; m_ten = 0; m_ptr = 0; m_q = 8'h00;
         return;
      end
      nq = m_q;
      if (m_owner >= 0 && r[m_owner]) begin
         oo = o[2*m_owner +: 2];
         if (oo == 2'd1) nq = w[8*m_owner +: 8];
         else if (oo == 2'd2) nq = 8'h00;
         else if (oo == 2'd3) nq = 8'hFF;
      end
      others = 0;
      for (int j = 0; j < N; j++) if (r[j] && j != m_owner) others = 1;
      yield = (m_owner < 0) || !r[m_owner] || (m_ten >= MH && others);
      if (yield) begin
         k = -1;
         for (int s = 0; s < N; s++) if (k < 0 && r[(m_ptr + s) % N]) k = (m_ptr + s) % N;
         if (k >= 0) begin
            m_owner = k; m_ten = 1; m_ptr = (k + 1) % N;
         end else begin
            m_owner = -1; m_ten = 0;
         end
      end else begin
         m_ten++;
      end
      m_q = nq;
   endtask

   task automatic step(input logic r_b, input logic [3:0] r, input logic [7:0] o, input logic [31:0] w);
      rst_b = r_b; req = r; op = o; wdata = w;
      model(r_b, r, o, w);
      @(posedge clk);
      #1;
      check("gnt",     32'(gnt),     (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      check("gnt_vld", 32'(gnt_vld), (m_owner >= 0) ? 32'd1 : 32'd0);
      check("gnt_id",  32'(gnt_id),  (m_owner >= 0) ? 32'(m_owner) : 32'd0);
      check("q",       32'(q),       32'(m_q));
   endtask

   initial begin
      rst_b = 1'b0; req = '0; op = '0; wdata = '0;

      // reset held with every requester asking to set the register
      step(0, 4'b1111, 8'hFF, 32'hFFFF_FFFF);
      step(0, 4'b1111, 8'hFF, 32'hFFFF_FFFF);
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_vld", 32'(gnt_vld), 32'd0);
      check("rst_q",   32'(q), 32'h00);
      step(1, 4'b0000, 8'h00, 32'h0);

      // single requester 2 loads A5
      step(1, 4'b0100, 8'h10, 32'h00A5_0000);
      check("single_gnt", 32'(gnt), 32'b0100);
      check("single_id",  32'(gnt_id), 32'd2);
      step(1, 4'b0100, 8'h10, 32'h00A5_0000);
      check("single_q", 32'(q), 32'hA5);
      step(1, 4'b0000, 8'h00, 32'h0);

      // owner 0: set, clear, hold
      step(1, 4'b0001, 8'h00, 32'h0);
      step(1, 4'b0001, 8'h03, 32'h0);
      check("set_q", 32'(q), 32'hFF);
      step(1, 4'b0001, 8'h02, 32'h0);
      check("clr_q", 32'(q), 32'h00);
      step(1, 4'b0001, 8'h00, 32'h0);
      check("hold_q", 32'(q), 32'h00);
      step(1, 4'b0000, 8'h00, 32'h0);

      // full contention: MAX_HOLD cycles each in index order, then wrap to 0
      step(0, 4'b0000, 8'h00, 32'h0);
      for (int i = 0; i < 17; i++) begin
         step(1, 4'b1111, 8'h00, 32'h0);
         check("rr_id", 32'(gnt_id), (i < 16) ? 32'(i / MH) : 32'd0);
      end

      // early release by owner 1 hands straight to 3; requester 0 write is ignored
      step(0, 4'b0000, 8'h00, 32'h0);
      step(1, 4'b0010, 8'h00, 32'h0);
      step(1, 4'b1011, 8'h01, 32'h0000_0077);
      step(1, 4'b1001, 8'h01, 32'h0000_0077);
      check("early_gnt", 32'(gnt), 32'b1000);
      check("early_vld", 32'(gnt_vld), 32'd1);
      check("early_q",   32'(q), 32'h00);

      // reset while owner 1 loads 3C: load discarded, pointer back to 0
      step(1, 4'b0000, 8'h00, 32'h0);
      step(1, 4'b0010, 8'h00, 32'h0);
      step(0, 4'b0010, 8'h04, 32'h0000_3C00);
      check("midrst_q",   32'(q), 32'h00);
      check("midrst_gnt", 32'(gnt), 32'd0);
      step(1, 4'b1010, 8'h00, 32'h0);
      check("midrst_scan", 32'(gnt), 32'b0010);

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 39) != 0), 4'($urandom_range(0, 15)),
              8'($urandom), 32'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
